// File: rtl/byte_rr_scheduler.sv
// Round-robin scheduler sharing one 8-bit phy_tx byte lane between four valid/ready/last
// requesters; one grant at a time, held for a packet or up to MAX_BURST bytes.
module byte_rr_scheduler #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       valid_in2,
  input  logic       valid_in3,
  input  logic       last_in0,
  input  logic       last_in1,
  input  logic       last_in2,
  input  logic       last_in3,
  output logic       ready_out0,
  output logic       ready_out1,
  output logic       ready_out2,
  output logic       ready_out3,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       last_out,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic {StIdle, StGrant} state_e;

  localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);

  state_e     state_q, state_d;
  logic [1:0] grant_d, rr_ptr_q, rr_ptr_d, winner;
  logic [7:0] burst_cnt_q, burst_cnt_d, data_d;
  logic       valid_d, last_d, xfer;
  logic [3:0] vin, lin, ready;
  logic [7:0] din [4];

  assign vin    = {valid_in3, valid_in2, valid_in1, valid_in0};
  assign lin    = {last_in3, last_in2, last_in1, last_in0};
  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;

  // Scan from the farthest offset down so the closest valid requester to rr_ptr wins.
  always_comb begin
    winner = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (vin[rr_ptr_q + 2'(i)]) winner = rr_ptr_q + 2'(i);
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == StGrant) ready[grant] = vin[grant];
  end

  assign ready_out0 = ready[0];
  assign ready_out1 = ready[1];
  assign ready_out2 = ready[2];
  assign ready_out3 = ready[3];
  assign busy       = (state_q == StGrant);
  assign xfer       = ready[grant];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    data_d      = 8'd0;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && (vin != 4'd0)) begin
          grant_d     = winner;
          burst_cnt_d = 8'd0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (xfer) begin
          data_d      = din[grant];
          valid_d     = 1'b1;
          last_d      = lin[grant];
          burst_cnt_d = burst_cnt_q + 8'd1;
          // Truncation releases without forcing last; the requester resumes later.
          if (lin[grant] || (burst_cnt_q == BurstLast)) begin
            state_d  = StIdle;
            rr_ptr_d = grant + 2'd1;
          end
        end else begin
          state_d  = StIdle;
          rr_ptr_d = grant + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant       <= 2'd0;
      rr_ptr_q    <= 2'd0;
      burst_cnt_q <= 8'd0;
      data_out    <= 8'd0;
      valid_out   <= 1'b0;
      last_out    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      data_out    <= data_d;
      valid_out   <= valid_d;
      last_out    <= last_d;
    end
  end

endmodule

// File: tb/tb_byte_rr_scheduler.sv
// Randomized self-checking bench for byte_rr_scheduler against a packet-level
// round-robin reference model.
module tb_byte_rr_scheduler;

  localparam int MaxBurst = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] din [4];
  logic [3:0] vin = '0;
  logic [3:0] lin = '0;
  logic       ready_out0, ready_out1, ready_out2, ready_out3;
  logic [7:0] data_out;
  logic       valid_out, last_out, busy;
  logic [1:0] grant;
  logic [3:0] rdy;

  assign rdy = {ready_out3, ready_out2, ready_out1, ready_out0};

  always #5 clk = ~clk;

  byte_rr_scheduler #(.MAX_BURST(MaxBurst)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .data_in0  (din[0]),
    .data_in1  (din[1]),
    .data_in2  (din[2]),
    .data_in3  (din[3]),
    .valid_in0 (vin[0]),
    .valid_in1 (vin[1]),
    .valid_in2 (vin[2]),
    .valid_in3 (vin[3]),
    .last_in0  (lin[0]),
    .last_in1  (lin[1]),
    .last_in2  (lin[2]),
    .last_in3  (lin[3]),
    .ready_out0(ready_out0),
    .ready_out1(ready_out1),
    .ready_out2(ready_out2),
    .ready_out3(ready_out3),
    .data_out  (data_out),
    .valid_out (valid_out),
    .last_out  (last_out),
    .grant     (grant),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: who owns the lane, how many bytes it has moved, and whose turn is next.
  bit         m_active;
  int         m_owner, m_moved, m_next;
  logic [7:0] e_data;
  logic       e_valid, e_last;

  // Requester sources: bytes left in the current packet and a running byte sequence.
  int rem [4];
  int seq [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_owner  = 0;
    m_moved  = 0;
    m_next   = 0;
    e_data   = 8'd0;
    e_valid  = 1'b0;
    e_last   = 1'b0;
  endtask

  task automatic release_lane();
    m_active = 0;
    m_next   = (m_owner + 1) % 4;
  endtask

  // One clock: check registered outputs, drive new inputs, check combinational outputs,
  // then advance the model over the coming rising edge.
  task automatic cycle(input bit en_val, input int gap_pct);
    bit [3:0] exp_rdy;
    @(negedge clk);
    check_val("data_out", data_out, e_data);
    check_val("valid_out", valid_out, e_valid);
    check_val("last_out", last_out, e_last);
    reset  = 1'b0;
    enable = en_val;
    for (int x = 0; x < 4; x++) begin
      if (rem[x] == 0) rem[x] = $urandom_range(7, 1);
      vin[x] = ($urandom_range(99) >= gap_pct);
      din[x] = 8'((x << 6) | (seq[x] & 63));
      lin[x] = (rem[x] == 1);
    end
    #1;
    exp_rdy = '0;
    if (m_active && vin[m_owner]) exp_rdy[m_owner] = 1'b1;
    for (int x = 0; x < 4; x++) check_val($sformatf("ready_out%0d", x), rdy[x], exp_rdy[x]);
    check_val("grant", grant, m_owner);
    check_val("busy", busy, m_active);

    e_data  = 8'd0;
    e_valid = 1'b0;
    e_last  = 1'b0;
    if (!m_active) begin
      if (enable && vin != 4'd0) begin
        for (int k = 0; k < 4; k++) begin
          if (vin[(m_next + k) % 4]) begin
            m_owner  = (m_next + k) % 4;
            m_active = 1;
            m_moved  = 0;
            break;
          end
        end
      end
    end else if (vin[m_owner]) begin
      e_data  = din[m_owner];
      e_valid = 1'b1;
      e_last  = lin[m_owner];
      m_moved++;
      if (lin[m_owner] || m_moved == MaxBurst) release_lane();
    end else begin
      release_lane();
    end
    for (int x = 0; x < 4; x++) begin
      if (exp_rdy[x]) begin
        seq[x]++;
        rem[x]--;
      end
    end
  endtask

  initial begin
    for (int x = 0; x < 4; x++) begin
      rem[x] = 0;
      seq[x] = 0;
      din[x] = 8'd0;
    end
    model_reset();

    // First cycle checks reset values, then releases reset.
    cycle(1'b1, 20);
    for (int n = 0; n < 300; n++) cycle($urandom_range(99) < 85, 20);
    // Saturated requesters exercise rotation and burst truncation.
    for (int n = 0; n < 80; n++) cycle(1'b1, 0);
    for (int n = 0; n < 30; n++) cycle(1'b0, 10);
    for (int n = 0; n < 100; n++) cycle(1'b1, 40);

    // Asynchronous reset mid-burst.
    for (int n = 0; n < 50; n++) begin
      cycle(1'b1, 0);
      if (busy && m_active) break;
    end
    check_val("busy_before_reset", busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_valid_out", valid_out, 1'b0);
    check_val("rst_data_out", data_out, 8'd0);
    check_val("rst_last_out", last_out, 1'b0);
    check_val("rst_ready", rdy, 4'd0);
    check_val("rst_grant", grant, 2'd0);
    model_reset();

    for (int n = 0; n < 200; n++) cycle($urandom_range(99) < 90, 15);
    for (int n = 0; n < 40; n++) cycle(1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
